// File: rtl/stream_downsize.sv
// stream_downsize: splits one wide word (T_DATA_RATIO lanes + keep + last)
// into narrow beats of its kept lanes, lowest lane first.
//   clk, rst_n                : clock, synchronous active-low reset
//   s_data_i/keep/last/valid  : wide word in; s_ready_o accepts it
//   m_data_o/last/valid       : narrow beat out; m_ready_i accepts it
module stream_downsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int R  = T_DATA_RATIO;
  localparam int W  = T_DATA_WIDTH;
  localparam int IW = (R > 2) ? $clog2(R) : 1;
  localparam logic [R-1:0] ONE = R'(1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t         state_q;
  logic [W-1:0]   data_q [R-1:0];
  logic [R-1:0]   mask_q;
  logic           last_q;

  logic [R-1:0]   rest;
  logic           final_beat;
  logic           fire_m;
  logic           acc;
  logic [W-1:0]   n_data [R-1:0];
  logic [R-1:0]   n_mask;
  logic           n_last;
  logic           n_valid;
  logic           n_beat_last;
  logic [IW-1:0]  idx;

  // Mask with its lowest set bit removed: empty means the current
  // beat is the final one of the held word.
  assign rest       = mask_q & (mask_q - ONE);
  assign final_beat = (state_q == SEND) && (rest == '0);
  assign fire_m     = m_valid_o & m_ready_i;

  assign s_ready_o = rst_n &
    ((state_q == EMPTY) | (final_beat & m_ready_i));
  assign acc = s_valid_i & s_ready_o;

  // Next held word/mask, then the beat it presents next cycle.
  // An all-zero keep word is consumed without being loaded.
  always_comb begin
    n_data = data_q;
    n_mask = mask_q;
    n_last = last_q;
    if (acc && (s_keep_i != '0)) begin
      n_data = s_data_i;
      n_mask = s_keep_i;
      n_last = s_last_i;
    end else if (fire_m) begin
      n_mask = rest;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (n_mask[i]) idx = IW'(i);
    end
  end

  assign n_valid     = (n_mask != '0);
  assign n_beat_last =
    n_last && ((n_mask & (n_mask - ONE)) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      mask_q    <= '0;
      last_q    <= 1'b0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
      for (int i = 0; i < R; i++) data_q[i] <= '0;
    end else begin
      state_q   <= n_valid ? SEND : EMPTY;
      mask_q    <= n_mask;
      last_q    <= n_last;
      data_q    <= n_data;
      m_valid_o <= n_valid;
      m_last_o  <= n_valid & n_beat_last;
      m_data_o  <= n_valid ? n_data[idx] : '0;
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: directed vector table plus hand sequences
// for backpressure and mid-word reset.
module tb_stream_downsize;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s_data [1:0];
  logic [1:0] s_keep;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_downsize #(
    .T_DATA_WIDTH(4),
    .T_DATA_RATIO(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data),
    .s_keep_i (s_keep),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  // chk: 0 = skip, 1 = ready/valid (+data/last when valid), 2 = all
  typedef struct {
    logic       rst;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] keep;
    logic       last;
    logic       sv;
    logic       mr;
    int         chk;
    logic       sr;
    logic       mv;
    logic [3:0] md;
    logic       ml;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst, logic [3:0] d0, logic [3:0] d1, logic [1:0] keep,
    logic last, logic sv, logic mr, int chk,
    logic sr, logic mv, logic [3:0] md, logic ml);
    vec_t v;
    v.rst = rst; v.d0 = d0; v.d1 = d1; v.keep = keep;
    v.last = last; v.sv = sv; v.mr = mr; v.chk = chk;
    v.sr = sr; v.mv = mv; v.md = md; v.ml = ml;
    return v;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] d0, logic [3:0] d1,
                       logic [1:0] keep, logic last, logic sv,
                       logic mr);
    @(negedge clk);
    rst_n = rst; s_data[0] = d0; s_data[1] = d1;
    s_keep = keep; s_last = last; s_valid = sv; m_ready = mr;
    #1;
  endtask

  task automatic expect_out(string nm, logic sr, logic mv,
                            logic [3:0] md, logic ml);
    check({nm, ".s_ready"}, 8'(s_ready), 8'(sr));
    check({nm, ".m_valid"}, 8'(m_valid), 8'(mv));
    check({nm, ".m_data"}, 8'(m_data), 8'(md));
    check({nm, ".m_last"}, 8'(m_last), 8'(ml));
  endtask

  int beats_a;

  initial begin
    rst_n = 1'b0; s_data[0] = '0; s_data[1] = '0;
    s_keep = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;

    // rst d0 d1 keep last sv mr | chk sr mv md ml
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0));
    // full word
    vecs.push_back(mk(1, 5, 4'hA, 2'b11, 1, 1, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 1, 5, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 1, 4'hA, 1));
    // sparse keep
    vecs.push_back(mk(1, 3, 4'hE, 2'b01, 1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 4'hC, 2'b10, 1, 1, 1, 1, 1, 1, 3, 1));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 1, 4'hC, 1));
    // streaming, last only on third word
    vecs.push_back(mk(1, 0, 1, 2'b11, 0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 3, 2'b11, 0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2, 3, 2'b11, 0, 1, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 4, 5, 2'b11, 1, 1, 1, 1, 0, 1, 2, 0));
    vecs.push_back(mk(1, 4, 5, 2'b11, 1, 1, 1, 1, 1, 1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 1, 4, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 1, 5, 1));
    // zero keep dropped, then a normal word
    vecs.push_back(mk(1, 7, 7, 2'b00, 1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8, 9, 2'b11, 1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 1, 8, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 1, 1, 1, 9, 1));
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 0, 1, 2, 1, 0, 9, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      string nm;
      v = vecs[i];
      nm = $sformatf("vec%0d", i);
      drive(v.rst, v.d0, v.d1, v.keep, v.last, v.sv, v.mr);
      if (v.chk != 0) begin
        check({nm, ".s_ready"}, 8'(s_ready), 8'(v.sr));
        check({nm, ".m_valid"}, 8'(m_valid), 8'(v.mv));
        if (v.chk == 2) begin
          check({nm, ".m_data"}, 8'(m_data), 8'(v.chk == 2 && !v.mv ?
                4'h0 : v.md));
          check({nm, ".m_last"}, 8'(m_last), 8'(v.ml));
        end else if (v.mv) begin
          check({nm, ".m_data"}, 8'(m_data), 8'(v.md));
          check({nm, ".m_last"}, 8'(m_last), 8'(v.ml));
        end
      end
    end

    // Backpressure: first beat held for 3 cycles, then drained.
    drive(1, 5, 4'hA, 2'b11, 1, 1, 1);
    check("bp.accept", 8'(s_ready), 8'(1));
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'hB, 4'hB, 2'b11, 0, 1, 0);
      expect_out($sformatf("bp.hold%0d", k), 0, 1, 5, 0);
    end
    beats_a = 0;
    drive(1, 0, 0, 2'b00, 0, 0, 1);
    expect_out("bp.rel0", 0, 1, 5, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 1);
    expect_out("bp.rel1", 1, 1, 4'hA, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 2'b00, 0, 0, 1);
      if (m_valid) beats_a++;
    end
    check("bp.no_dup", 8'(beats_a), 8'(0));

    // Reset while beat 0x5 is pending under backpressure.
    drive(1, 5, 4'hA, 2'b11, 1, 1, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    check("rst.pending", 8'(m_data), 8'(5));
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    expect_out("rst.clear", 0, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 1);
    expect_out("rst.release", 1, 0, 0, 0);
    beats_a = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 2'b00, 0, 0, 1);
      if (m_valid) beats_a++;
    end
    check("rst.no_stale", 8'(beats_a), 8'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
